// File: rtl/board_byte_writer_if.sv
// Byte-stream input and 32-bit RAM write port of the board byte writer.
// Signal names match the original flat port list so the block stays a drop-in replacement.
interface board_byte_writer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic              reset_req;

  // Writer side: consumes the byte stream and drives the RAM port.
  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, address, byteenable, chipselect, write, writedata, clken, reset_req
  );

  // Environment side: the byte source, and the RAM as an observer.
  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, address, byteenable, chipselect, write, writedata, clken, reset_req
  );
endinterface

// File: rtl/board_byte_writer.sv
// Packs a stream of board cell bytes into 32-bit words and writes them to
// consecutive RAM words starting at BASE_ADDR. A run is truncated at the end of the RAM.
module board_byte_writer #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 10024,
  parameter int unsigned ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  board_byte_writer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        lane;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic              last_q;
  logic [ADDR_W-1:0] wc_q;
  logic              ovf_q;
  logic              done_q;

  logic              ready_c;
  logic              wr_c;
  logic              busy_c;
  logic              at_end;
  logic [31:0]       lane_data;
  logic [3:0]        lane_mask;

  assign at_end    = (ptr == ADDR_W'(DEPTH - 1));
  assign lane_data = 32'(bus.in_data) << {lane, 3'b000};
  assign lane_mask = 4'b0001 << lane;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d = state;
    ready_c = 1'b0;
    wr_c    = 1'b0;
    busy_c  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (bus.in_valid && (lane == 2'd3 || bus.in_last)) state_d = WRITE;
      end
      WRITE: begin
        wr_c    = 1'b1;
        busy_c  = 1'b1;
        state_d = (last_q || at_end) ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word assembly, address pointer and run status.
  // The pointer only advances while below DEPTH-1, so it stays in range even
  // when the final byte of a run lands in the last RAM word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= '0;
      lane   <= '0;
      data_q <= '0;
      be_q   <= '0;
      last_q <= 1'b0;
      wc_q   <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ptr    <= ADDR_W'(BASE_ADDR);
            lane   <= '0;
            data_q <= '0;
            be_q   <= '0;
            last_q <= 1'b0;
            wc_q   <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            data_q <= data_q | lane_data;
            be_q   <= be_q | lane_mask;
            lane   <= lane + 2'd1;
            last_q <= bus.in_last;
          end
        end
        WRITE: begin
          wc_q   <= wc_q + 1'b1;
          lane   <= '0;
          data_q <= '0;
          be_q   <= '0;
          last_q <= 1'b0;
          if (!at_end) ptr <= ptr + 1'b1;
          if (at_end && !last_q) ovf_q <= 1'b1;
          if (at_end || last_q) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.address    = ptr;
  assign bus.byteenable = wr_c ? be_q : 4'b0000;
  assign bus.chipselect = wr_c;
  assign bus.write      = wr_c;
  assign bus.writedata  = data_q;
  assign bus.clken      = 1'b1;
  assign bus.reset_req  = 1'b0;

  assign busy       = busy_c;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_board_byte_writer.sv
// Directed bench for board_byte_writer: word packing, partial words, RAM-end
// truncation, back-pressure timing, asynchronous reset and ignored starts.
module tb_board_byte_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start_hi = 1'b0;
  logic busy0, done0, ovf0;
  logic busy_hi, done_hi, ovf_hi;
  logic [13:0] wc0, wc_hi;

  int n_checks = 0;
  int n_fail = 0;
  int n_wr0 = 0;

  always #5 clk = ~clk;

  board_byte_writer_if #(.ADDR_W(14)) bus0();
  board_byte_writer_if #(.ADDR_W(14)) bus_hi();

  board_byte_writer #(.BASE_ADDR(0), .DEPTH(10024), .ADDR_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus0.slave),
    .busy(busy0), .done(done0), .overflow(ovf0), .word_count(wc0)
  );

  board_byte_writer #(.BASE_ADDR(10022), .DEPTH(10024), .ADDR_W(14)) dut_hi (
    .clk(clk), .reset_n(reset_n), .start(start_hi), .bus(bus_hi.slave),
    .busy(busy_hi), .done(done_hi), .overflow(ovf_hi), .word_count(wc_hi)
  );

  // Count RAM writes from the main instance.
  always @(negedge clk) if (bus0.write) n_wr0++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Offers one byte; returns at the negedge after the edge that accepted it.
  task automatic send(input logic [7:0] b, input logic last);
    bit got = 1'b0;
    bus0.in_data  = b;
    bus0.in_valid = 1'b1;
    bus0.in_last  = last;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus0.in_ready) got = 1'b1;
      @(negedge clk);
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_write(input string tag, input logic [13:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    check({tag, "_write"}, 32'(bus0.write), 32'd1);
    check({tag, "_cs"}, 32'(bus0.chipselect), 32'd1);
    check({tag, "_addr"}, 32'(bus0.address), 32'(a));
    check({tag, "_data"}, bus0.writedata, d);
    check({tag, "_be"}, 32'(bus0.byteenable), 32'(be));
    check({tag, "_ready"}, 32'(bus0.in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_base;
    int acc;
    int hi_writes;
    int hi_sent;
    logic r;
    logic [13:0] hi_addr [2];
    logic [31:0] hi_data [2];
    logic [3:0]  hi_be [2];

    bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.in_last = 1'b0;
    bus_hi.in_data = '0; bus_hi.in_valid = 1'b0; bus_hi.in_last = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(bus0.in_ready), 32'd0);
    check("rst_write", 32'(bus0.write), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_wc", 32'(wc0), 32'd0);
    check("rst_clken", 32'(bus0.clken), 32'd1);
    check("rst_reset_req", 32'(bus0.reset_req), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus0.in_ready), 32'd0);

    // Full word 11,22,33,44: write seen in the cycle right after 44 is accepted
    pulse_start();
    check("s1_busy", 32'(busy0), 32'd1);
    check("s1_ready", 32'(bus0.in_ready), 32'd1);
    send(8'h11, 1'b0);
    check("s1_nowrite", 32'(bus0.write), 32'd0);
    check("s1_be_idle", 32'(bus0.byteenable), 32'd0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check_write("s1", 14'd0, 32'h44332211, 4'hF);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("s1_after_write", 32'(bus0.write), 32'd0);
    check("s1_after_be", 32'(bus0.byteenable), 32'd0);
    check("s1_wc", 32'(wc0), 32'd1);
    check("s1_addr_next", 32'(bus0.address), 32'd1);
    apply_reset();

    // Six bytes with in_last on the sixth: full word then a two-lane word
    wr_base = n_wr0;
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    check_write("s2w0", 14'd0, 32'h04030201, 4'hF);
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    check_write("s2w1", 14'd1, 32'h00000605, 4'h3);
    bus0.in_valid = 1'b0;
    bus0.in_last = 1'b0;
    @(negedge clk);
    check("s2_done", 32'(done0), 32'd1);
    check("s2_busy", 32'(busy0), 32'd0);
    check("s2_wc", 32'(wc0), 32'd2);
    check("s2_ovf", 32'(ovf0), 32'd0);
    check("s2_ready", 32'(bus0.in_ready), 32'd0);
    check("s2_nwrites", 32'(n_wr0 - wr_base), 32'd2);
    // start from DONE begins a new run and clears done
    pulse_start();
    check("s2_restart_done", 32'(done0), 32'd0);
    check("s2_restart_wc", 32'(wc0), 32'd0);
    check("s2_restart_addr", 32'(bus0.address), 32'd0);
    apply_reset();

    // Continuous in_valid: 8 bytes accepted in 10 cycles, ready low while writing
    pulse_start();
    bus0.in_valid = 1'b1;
    bus0.in_last = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.in_ready) acc++;
      if (bus0.write) check("s3_ready_in_write", 32'(bus0.in_ready), 32'd0);
      bus0.in_data = 8'(i);
      @(negedge clk);
    end
    check("s3_accepted", 32'(acc), 32'd8);
    check("s3_wc", 32'(wc0), 32'd2);
    bus0.in_valid = 1'b0;
    apply_reset();

    // start pulsed in FILL is ignored: second word still goes to address 1
    pulse_start();
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    bus0.in_valid = 1'b0;
    pulse_start();
    check("s4_busy", 32'(busy0), 32'd1);
    check("s4_addr", 32'(bus0.address), 32'd1);
    check("s4_wc", 32'(wc0), 32'd1);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    check_write("s4", 14'd1, 32'hDDCCBBAA, 4'hF);
    bus0.in_valid = 1'b0;
    apply_reset();

    // Asynchronous reset mid-word after two bytes
    pulse_start();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    bus0.in_valid = 1'b0;
    wr_base = n_wr0;
    #1 reset_n = 1'b0;
    #1;
    check("s5_ready", 32'(bus0.in_ready), 32'd0);
    check("s5_write", 32'(bus0.write), 32'd0);
    check("s5_cs", 32'(bus0.chipselect), 32'd0);
    check("s5_be", 32'(bus0.byteenable), 32'd0);
    check("s5_data", bus0.writedata, 32'd0);
    check("s5_addr", 32'(bus0.address), 32'd0);
    check("s5_busy", 32'(busy0), 32'd0);
    check("s5_done", 32'(done0), 32'd0);
    check("s5_ovf", 32'(ovf0), 32'd0);
    check("s5_wc", 32'(wc0), 32'd0);
    check("s5_clken", 32'(bus0.clken), 32'd1);
    check("s5_reset_req", 32'(bus0.reset_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("s5_nowrite", 32'(n_wr0 - wr_base), 32'd0);
    pulse_start();
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send(8'hE4, 1'b0);
    check_write("s5_new", 14'd0, 32'hE4E3E2E1, 4'hF);
    bus0.in_valid = 1'b0;

    // BASE_ADDR=10022, 12 bytes offered without in_last: truncated after two words
    start_hi = 1'b1;
    @(negedge clk);
    start_hi = 1'b0;
    hi_writes = 0;
    hi_sent = 0;
    bus_hi.in_data = 8'd1;
    bus_hi.in_valid = 1'b1;
    for (int i = 0; i < 40 && hi_sent < 12 && !done_hi; i++) begin
      if (bus_hi.write) begin
        if (hi_writes < 2) begin
          hi_addr[hi_writes] = bus_hi.address;
          hi_data[hi_writes] = bus_hi.writedata;
          hi_be[hi_writes]   = bus_hi.byteenable;
        end
        hi_writes++;
      end
      r = bus_hi.in_ready;
      @(negedge clk);
      if (r) begin
        hi_sent++;
        bus_hi.in_data = 8'(hi_sent + 1);
      end
    end
    bus_hi.in_valid = 1'b0;
    @(negedge clk);
    check("s6_nwrites", 32'(hi_writes), 32'd2);
    check("s6_addr0", 32'(hi_addr[0]), 32'd10022);
    check("s6_data0", hi_data[0], 32'h04030201);
    check("s6_be0", 32'(hi_be[0]), 32'hF);
    check("s6_addr1", 32'(hi_addr[1]), 32'd10023);
    check("s6_data1", hi_data[1], 32'h08070605);
    check("s6_ovf", 32'(ovf_hi), 32'd1);
    check("s6_done", 32'(done_hi), 32'd1);
    check("s6_wc", 32'(wc_hi), 32'd2);
    check("s6_busy", 32'(busy_hi), 32'd0);
    check("s6_ptr_limit", 32'(bus_hi.address), 32'd10023);
    check("s6_ready", 32'(bus_hi.in_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
